fetch_stage: RTL

//  Instruction-fetch (IF) stage of the 5-stage MIPS-Lite pipeline, directly upstream of decode.

---
 rtl/fetch_stage.sv | 70 +++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS-Lite IF stage owning the PC and the IF/ID register, with stall, branch redirect and sticky halt.
// FETCH_PERF_CNT_EN adds saturating fetch/stall counters on fetchCount and stallCount.
module fetch_stage #(
  parameter int ADDRESSWIDTH = 32,
  parameter int INSTWIDTH = 32,
  parameter logic [ADDRESSWIDTH-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hazardDetected,
  input  logic                    branchTaken,
  input  logic [ADDRESSWIDTH-1:0] branchTarget,
  input  logic                    haltSignal,
  output logic [ADDRESSWIDTH-1:0] imemAddr,
  input  logic [INSTWIDTH-1:0]    imemData,
  output logic [INSTWIDTH-1:0]    instrOut,
  output logic [ADDRESSWIDTH-1:0] pcOut,
  output logic                    validOut,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]             fetchCount,
  output logic [31:0]             stallCount,
`endif
  output logic                    halted
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state, state_nx;
  logic [ADDRESSWIDTH-1:0] pc, pc_nx, pco_nx;
  logic [INSTWIDTH-1:0] instr_nx;
  logic valid_nx, halt_act, br_act, stall_act, norm_act;
  assign imemAddr = pc;
  assign halted = state == HALTED;
  always_comb begin
    halt_act = (state == HALTED) || haltSignal;
    br_act = !halt_act && branchTaken;
    stall_act = !halt_act && !branchTaken && hazardDetected;
    norm_act = !halt_act && !branchTaken && !hazardDetected;
    state_nx = halt_act ? HALTED : RUN;
    pc_nx = br_act ? {branchTarget[ADDRESSWIDTH-1:2], 2'b00} :
            norm_act ? pc + ADDRESSWIDTH'(4) : pc;
    instr_nx = norm_act ? imemData : stall_act ? instrOut : '0;
    pco_nx = norm_act ? pc : pcOut;
    valid_nx = norm_act || (stall_act && validOut);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      pc <= {RESET_PC[ADDRESSWIDTH-1:2], 2'b00};
      instrOut <= '0;
      pcOut <= '0;
      validOut <= 1'b0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      instrOut <= instr_nx;
      pcOut <= pco_nx;
      validOut <= valid_nx;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetchCount <= '0;
      stallCount <= '0;
    end else begin
      if (norm_act && fetchCount != '1) fetchCount <= fetchCount + 32'd1;
      if (stall_act && stallCount != '1) stallCount <= stallCount + 32'd1;
    end
  end
`endif
endmodule
